// File: rtl/alu_checker.sv
// Consumer-side ALU response checker: accept, recompute in stage 1, register the compare and count.
// Optional ALU_CHECKER_SAT_EN makes pass_count/fail_count saturate instead of wrap.
module alu_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             halt_on_fail,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             halted,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [1:0]       fail_op,
  output logic [WIDTH-1:0] fail_got,
  output logic [WIDTH-1:0] fail_exp
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t           state_q;
  logic             halted_q;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_got_q;
  logic [1:0]       s1_op_q;
  logic             mismatch_q;
  logic [CNT_W-1:0] pass_count_q, fail_count_q;
  logic [CNT_W-1:0] pass_count_d, fail_count_d;
  logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_got_q, fail_exp_q;
  logic [1:0]       fail_op_q;

  logic [WIDTH-1:0] exp_d;
  logic             accept, pass_now, fail_now, halt_now;

  // in_ready comes straight from state so it reads 1 as soon as reset drops.
  assign in_ready = !reset && (state_q != HALTED);
  assign accept   = in_valid && in_ready;

  always_comb begin
    exp_d = '0;
    case (s1_op_q)
      2'b00: exp_d = s1_a_q + s1_b_q;
      2'b01: exp_d = s1_a_q - s1_b_q;
      2'b10: exp_d = s1_a_q & s1_b_q;
      2'b11: exp_d = s1_a_q | s1_b_q;
      default: exp_d = '0;
    endcase
    fail_now = s1_valid_q && (exp_d != s1_got_q);
    pass_now = s1_valid_q && (exp_d == s1_got_q);
    halt_now = fail_now && halt_on_fail && (state_q == RUN);
`ifdef ALU_CHECKER_SAT_EN
    pass_count_d = (pass_now && (pass_count_q != '1)) ? pass_count_q + CNT_W'(1) : pass_count_q;
    fail_count_d = (fail_now && (fail_count_q != '1)) ? fail_count_q + CNT_W'(1) : fail_count_q;
`else
    pass_count_d = pass_now ? pass_count_q + CNT_W'(1) : pass_count_q;
    fail_count_d = fail_now ? fail_count_q + CNT_W'(1) : fail_count_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      halted_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_got_q     <= '0;
      s1_op_q      <= '0;
      mismatch_q   <= 1'b0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_op_q    <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
    end else if (clear) begin
      state_q      <= IDLE;
      halted_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      mismatch_q   <= 1'b0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_op_q    <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
    end else begin
      // A transaction arriving on the halting edge is dropped unchecked.
      s1_valid_q <= accept && !halt_now;
      if (accept) begin
        s1_a_q   <= a;
        s1_b_q   <= b;
        s1_op_q  <= ALUControl;
        s1_got_q <= ALUResult;
      end
      mismatch_q   <= fail_now;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
      if (fail_now && (fail_count_q == '0)) begin
        fail_a_q   <= s1_a_q;
        fail_b_q   <= s1_b_q;
        fail_op_q  <= s1_op_q;
        fail_got_q <= s1_got_q;
        fail_exp_q <= exp_d;
      end
      case (state_q)
        IDLE: if (accept) state_q <= RUN;
        RUN: if (halt_now) begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign mismatch   = mismatch_q;
  assign pass_count = pass_count_q;
  assign fail_count = fail_count_q;
  assign halted     = halted_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_op    = fail_op_q;
  assign fail_got   = fail_got_q;
  assign fail_exp   = fail_exp_q;

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: vector table, hand sequences for halt/clear/reset, random run vs model, CNT_W=2 overflow.
module tb_alu_checker;

  logic        clk = 1'b0;
  logic        reset, clear, halt_on_fail, in_valid, in_ready;
  logic [7:0]  a, b, ALUResult;
  logic [1:0]  ALUControl;
  logic        mismatch, halted;
  logic [15:0] pass_count, fail_count;
  logic [7:0]  fail_a, fail_b, fail_got, fail_exp;
  logic [1:0]  fail_op;

  logic        s_valid, s_ready, s_mismatch, s_halted;
  logic [1:0]  s_pass, s_fail, s_fail_op;
  logic [7:0]  s_fail_a, s_fail_b, s_fail_got, s_fail_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .halt_on_fail(halt_on_fail),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ALUControl(ALUControl), .ALUResult(ALUResult), .mismatch(mismatch),
    .pass_count(pass_count), .fail_count(fail_count), .halted(halted),
    .fail_a(fail_a), .fail_b(fail_b), .fail_op(fail_op),
    .fail_got(fail_got), .fail_exp(fail_exp)
  );

  alu_checker #(.WIDTH(8), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .clear(clear), .halt_on_fail(1'b0),
    .in_valid(s_valid), .in_ready(s_ready), .a(a), .b(b),
    .ALUControl(ALUControl), .ALUResult(ALUResult), .mismatch(s_mismatch),
    .pass_count(s_pass), .fail_count(s_fail), .halted(s_halted),
    .fail_a(s_fail_a), .fail_b(s_fail_b), .fail_op(s_fail_op),
    .fail_got(s_fail_got), .fail_exp(s_fail_exp)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] res;
    logic       pass;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [7:0] ref_alu(input int ra, input int rb, input int op);
    int r;
    case (op)
      0: r = (ra + rb) % 256;
      1: r = (ra - rb + 256) % 256;
      2: r = ra & rb;
      default: r = ra | rb;
    endcase
    return r[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb_, input logic [1:0] top, input logic [7:0] tr);
    a = ta; b = tb_; ALUControl = top; ALUResult = tr; in_valid = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int mp, mf;
    logic prev_fail, cur_fail, got_fail;
    logic [7:0] ra, rb, rr, re, ff_a, ff_b, ff_got, ff_exp;
    logic [1:0] rop, ff_op;
    logic v;

    reset = 1'b1; clear = 1'b0; halt_on_fail = 1'b0; in_valid = 1'b0; s_valid = 1'b0;
    a = '0; b = '0; ALUControl = '0; ALUResult = '0;
    #2;
    chk("rst_pass", pass_count, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_halted", halted, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fail_exp", fail_exp, 0);
    step();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    tbl[0] = '{23, 23, 2'b00, 46, 1'b1};
    tbl[1] = '{23, 23, 2'b01, 0, 1'b1};
    tbl[2] = '{23, 23, 2'b10, 23, 1'b1};
    tbl[3] = '{23, 23, 2'b11, 23, 1'b1};
    tbl[4] = '{200, 100, 2'b00, 44, 1'b1};
    tbl[5] = '{5, 7, 2'b01, 254, 1'b1};
    tbl[6] = '{23, 23, 2'b00, 45, 1'b0};
    tbl[7] = '{1, 2, 2'b11, 0, 1'b0};
    tbl[8] = '{8'hF0, 8'h3C, 2'b10, 8'h30, 1'b1};
    tbl[9] = '{0, 1, 2'b01, 255, 1'b1};
    mp = 0; mf = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      drive(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res);
      step();
      in_valid = 1'b0;
      step();
      if (tbl[i].pass) mp++; else mf++;
      chk($sformatf("vec%0d_mismatch", i), mismatch, !tbl[i].pass);
      chk($sformatf("vec%0d_pass_count", i), pass_count, mp);
      chk($sformatf("vec%0d_fail_count", i), fail_count, mf);
    end
    chk("cap_got", fail_got, 45);
    chk("cap_exp", fail_exp, 46);
    chk("cap_op", fail_op, 0);
    chk("cap_a", fail_a, 23);
    chk("cap_b", fail_b, 23);
    chk("nohalt_halted", halted, 0);

    // Halt on failure with a back-to-back follower that must be dropped.
    do_clear();
    chk("clr_pass", pass_count, 0);
    chk("clr_fail", fail_count, 0);
    halt_on_fail = 1'b1;
    drive(10, 3, 2'b01, 0);
    step();
    drive(4, 4, 2'b00, 8);
    step();
    chk("halt_halted", halted, 1);
    chk("halt_in_ready", in_ready, 0);
    chk("halt_mismatch", mismatch, 1);
    chk("halt_fail_count", fail_count, 1);
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    step();
    chk("halt_pass_count", pass_count, 0);
    chk("halt_fail_count2", fail_count, 1);
    chk("halt_held", halted, 1);
    chk("halt_cap_exp", fail_exp, 7);
    chk("halt_mismatch_pulse", mismatch, 0);
    do_clear();
    halt_on_fail = 1'b0;
    step();
    chk("unhalt_halted", halted, 0);
    chk("unhalt_in_ready", in_ready, 1);
    chk("unhalt_fail_count", fail_count, 0);
    chk("unhalt_cap_exp", fail_exp, 0);

    // clear wins over a simultaneous valid.
    drive(4, 4, 2'b00, 8);
    clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    step(); step();
    chk("clr_prio_pass", pass_count, 0);

    // Asynchronous reset while a transaction sits in stage 1.
    drive(4, 4, 2'b00, 8);
    step(); in_valid = 1'b0; step();
    chk("pre_arst_pass", pass_count, 1);
    drive(9, 9, 2'b00, 0);
    step(); in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_pass", pass_count, 0);
    chk("arst_fail", fail_count, 0);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("post_arst_fail", fail_count, 0);
    chk("post_arst_pass", pass_count, 0);
    chk("post_arst_mismatch", mismatch, 0);

    // Random traffic against the model.
    mp = 0; mf = 0; prev_fail = 1'b0; got_fail = 1'b0;
    ff_a = '0; ff_b = '0; ff_op = '0; ff_got = '0; ff_exp = '0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 9) < 7);
      ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom);
      re = ref_alu(ra, rb, rop);
      rr = ($urandom_range(0, 1) == 1) ? re : 8'($urandom);
      a = ra; b = rb; ALUControl = rop; ALUResult = rr; in_valid = v;
      step();
      chk("rnd_mismatch", mismatch, prev_fail);
      cur_fail = v && (rr != re);
      if (v && rr == re) mp++;
      if (cur_fail) begin
        if (!got_fail) begin
          got_fail = 1'b1;
          ff_a = ra; ff_b = rb; ff_op = rop; ff_got = rr; ff_exp = re;
        end
        mf++;
      end
      prev_fail = cur_fail;
    end
    in_valid = 1'b0;
    step();
    chk("rnd_mismatch_last", mismatch, prev_fail);
    chk("rnd_pass", pass_count, mp);
    chk("rnd_fail", fail_count, mf);
    chk("rnd_cap_a", fail_a, ff_a);
    chk("rnd_cap_b", fail_b, ff_b);
    chk("rnd_cap_op", fail_op, ff_op);
    chk("rnd_cap_got", fail_got, ff_got);
    chk("rnd_cap_exp", fail_exp, ff_exp);

    // Narrow counters: overflow behaviour.
    do_clear();
    for (int i = 1; i <= 5; i++) begin
      a = 8'(i); b = 0; ALUControl = 2'b00; ALUResult = 8'(i); s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    step();
`ifdef ALU_CHECKER_SAT_EN
    chk("small_pass_ovf", s_pass, 3);
`else
    chk("small_pass_ovf", s_pass, 1);
`endif
    do_clear();
    for (int i = 1; i <= 5; i++) begin
      a = 8'(i); b = 0; ALUControl = 2'b00; ALUResult = 8'(i + 1); s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    step();
    chk("small_mismatch_ovf", s_mismatch, 1);
`ifdef ALU_CHECKER_SAT_EN
    chk("small_fail_ovf", s_fail, 3);
    chk("small_cap_a", s_fail_a, 1);
`else
    chk("small_fail_ovf", s_fail, 1);
    chk("small_cap_a", s_fail_a, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
